// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the memory_controller CPU port.
// One access in flight at a time. Enables are held ACCESS_CYCLES cycles, then a 1-cycle ack is given.
module mem_port_arbiter #(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ack,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ack,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_last_grant;
  logic              r_grant;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              r_rd_en;
  logic              r_wr_en;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_busy;

  logic              w_any;
  logic              w_winner;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_last_access;
  logic              w_rd_en_nxt;
  logic              w_wr_en_nxt;
  logic              w_ack0_nxt;
  logic              w_ack1_nxt;

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    w_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      w_winner = ~r_last_grant;
    end else begin
      w_winner = req1_valid;
    end
    w_sel_we      = w_winner ? req1_we    : req0_we;
    w_sel_addr    = w_winner ? req1_addr  : req0_addr;
    w_sel_wdata   = w_winner ? req1_wdata : req0_wdata;
    w_last_access = (r_state == S_ACCESS) && (r_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_state_nxt = S_ACCESS;
      S_ACCESS: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; valids are ignored outside IDLE.
  always_comb begin
    w_rd_en_nxt = 1'b0;
    w_wr_en_nxt = 1'b0;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_rd_en_nxt = ~w_sel_we;
          w_wr_en_nxt = w_sel_we;
        end
      end
      S_ACCESS: begin
        if (r_cnt != '0) begin
          w_rd_en_nxt = r_rd_en;
          w_wr_en_nxt = r_wr_en;
        end else begin
          w_ack0_nxt = ~r_grant;
          w_ack1_nxt = r_grant;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_en  <= 1'b0;
      r_wr_en  <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_busy   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_rd_en <= w_rd_en_nxt;
      r_wr_en <= w_wr_en_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_last_access && r_rd_en) begin
        if (r_grant) r_rdata1 <= mem_rdata;
        else         r_rdata0 <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_grant      <= w_winner;
        r_last_grant <= w_winner;
        r_cnt        <= CNT_LOAD;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
      end else if (r_state == S_ACCESS && r_cnt != '0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign req0_ack     = r_ack0;
  assign req1_ack     = r_ack1;
  assign req0_rdata   = r_rdata0;
  assign req1_rdata   = r_rdata1;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign mem_read_en  = r_rd_en;
  assign mem_write_en = r_wr_en;
  assign busy         = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two lanes (ACCESS_CYCLES 4 and 1), each with directed and random
// requesters, a transaction-level arbitration model feeding a scoreboard queue, and a cycle monitor.
module tb_mem_port_arbiter;

  typedef struct {
    int          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          gt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit lane_done [2];

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    logic [15:0] r;
    if (a == 16'h1234) r = 16'hBEEF;
    else               r = {a[6:0], a[15:7]} ^ 16'h3C96;
    return r;
  endfunction

  task automatic chk(input int ln, input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL lane%0d %s actual=%0h expected=%0h t=%0t", ln, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int AC = (g == 0) ? 4 : 1;

    logic        rst;
    logic        v [2];
    logic        we [2];
    logic [15:0] ad [2];
    logic [15:0] wd [2];
    logic        ack0, ack1, rd_en, wr_en, busy;
    logic [15:0] rdata0, rdata1, m_addr, m_wdata, m_rdata;

    exp_t        exp_q [$];
    int          cyc = 0;
    int          last_rst_cyc = -10;
    bit          chk_en = 0;
    int          free_at = 0;
    int          last_g = 1;
    logic [15:0] er [2];

    assign m_rdata = mem_model(m_addr);

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .ACCESS_CYCLES(AC)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(v[0]), .req0_we(we[0]), .req0_addr(ad[0]), .req0_wdata(wd[0]),
      .req0_ack(ack0), .req0_rdata(rdata0),
      .req1_valid(v[1]), .req1_we(we[1]), .req1_addr(ad[1]), .req1_wdata(wd[1]),
      .req1_ack(ack1), .req1_rdata(rdata1),
      .mem_addr(m_addr), .mem_wdata(m_wdata), .mem_rdata(m_rdata),
      .mem_read_en(rd_en), .mem_write_en(wr_en), .busy(busy)
    );

    // Reference: a decision is possible once the previous access has fully retired.
    initial begin : model
      forever begin
        @(posedge clk);
        if (rst === 1'b1) begin
          last_rst_cyc = cyc;
          free_at      = cyc + 1;
          last_g       = 1;
          chk_en       = 1;
        end else if (chk_en && cyc >= free_at && (v[0] || v[1])) begin : grant
          exp_t n;
          int   w;
          if (v[0] && v[1]) w = 1 - last_g;
          else              w = v[1] ? 1 : 0;
          n.port  = w;
          n.we    = we[w];
          n.addr  = ad[w];
          n.wdata = wd[w];
          n.rdata = mem_model(ad[w]);
          n.gt    = cyc;
          exp_q.push_back(n);
          last_g  = w;
          free_at = cyc + AC + 2;
        end
        cyc++;
      end
    end

    initial begin : monitor
      exp_t e;
      bit   have, xr, xw, xb, xa0, xa1;
      int   ap;
      forever begin
        @(negedge clk);
        if (chk_en) begin
          if (last_rst_cyc == cyc - 1) begin
            exp_q.delete();
            er[0] = '0;
            er[1] = '0;
          end
          have = (exp_q.size() > 0);
          if (have) e = exp_q[0];
          xr  = have && !e.we && cyc >= e.gt + 1 && cyc <= e.gt + AC;
          xw  = have &&  e.we && cyc >= e.gt + 1 && cyc <= e.gt + AC;
          xb  = have && cyc >= e.gt + 1 && cyc <= e.gt + AC + 1;
          xa0 = have && e.port == 0 && cyc == e.gt + AC + 1;
          xa1 = have && e.port == 1 && cyc == e.gt + AC + 1;
          chk(g, rd_en === xr, "read_en", 32'(rd_en), 32'(xr));
          chk(g, wr_en === xw, "write_en", 32'(wr_en), 32'(xw));
          chk(g, busy === xb, "busy", 32'(busy), 32'(xb));
          chk(g, ack0 === xa0, "ack0", 32'(ack0), 32'(xa0));
          chk(g, ack1 === xa1, "ack1", 32'(ack1), 32'(xa1));
          if (xr || xw) chk(g, m_addr === e.addr, "mem_addr", 32'(m_addr), 32'(e.addr));
          if (xw) chk(g, m_wdata === e.wdata, "mem_wdata", 32'(m_wdata), 32'(e.wdata));
          if (ack0 === 1'b1 || ack1 === 1'b1) begin
            ap = (ack1 === 1'b1) ? 1 : 0;
            if (!have) begin
              chk(g, 1'b0, "unexpected_ack", 32'(ap), 32'hFFFF_FFFF);
            end else begin
              chk(g, ap == e.port, "ack_port", 32'(ap), 32'(e.port));
              chk(g, cyc == e.gt + AC + 1, "ack_cycle", 32'(cyc), 32'(e.gt + AC + 1));
              if (!e.we) er[e.port] = e.rdata;
              void'(exp_q.pop_front());
            end
          end else if (have && cyc > e.gt + AC + 1) begin
            chk(g, 1'b0, "ack_timeout", 32'(cyc), 32'(e.gt + AC + 1));
            void'(exp_q.pop_front());
          end
          chk(g, rdata0 === er[0], "rdata0", 32'(rdata0), 32'(er[0]));
          chk(g, rdata1 === er[1], "rdata1", 32'(rdata1), 32'(er[1]));
        end
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic set_req(input int p, input bit w, input logic [15:0] a, input logic [15:0] d);
      we[p] = w;
      ad[p] = a;
      wd[p] = d;
      v[p]  = 1'b1;
    endtask

    // Returns one step into the ack cycle.
    task automatic wait_ack(input int p);
      bit got = 0;
      for (int k = 0; k < 64 && !got; k++) begin
        tick();
        if ((p == 0 ? ack0 : ack1) === 1'b1) got = 1;
      end
      chk(g, got, "wait_ack", 32'(got), 32'd1);
    endtask

    task automatic run_port(input int p, input int n, input int idle_max);
      for (int i = 0; i < n; i++) begin
        int idle = int'($urandom_range(idle_max, 0));
        if (idle > 0) begin
          v[p] = 1'b0;
          repeat (idle) tick();
        end
        set_req(p, 1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom));
        wait_ack(p);
      end
      v[p] = 1'b0;
    endtask

    initial begin : stim
      logic [15:0] prev1;
      rst = 1'b1;
      for (int p = 0; p < 2; p++) begin
        v[p] = 1'b0; we[p] = 1'b0; ad[p] = '0; wd[p] = '0;
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // First tie after reset goes to port 0; read 0x1234 returns 0xBEEF.
      set_req(0, 1'b0, 16'h1234, 16'h0);
      set_req(1, 1'b0, 16'h0042, 16'h0);
      wait_ack(0);
      v[0] = 1'b0;
      chk(g, rdata0 === 16'hBEEF, "rdata_beef", 32'(rdata0), 32'h0000_BEEF);
      wait_ack(1);
      v[1] = 1'b0;
      tick();

      // Write leaves the requester's read data untouched.
      prev1 = mem_model(16'h0042);
      set_req(1, 1'b1, 16'h00FF, 16'hA5A5);
      wait_ack(1);
      v[1] = 1'b0;
      chk(g, rdata1 === prev1, "write_keeps_rdata", 32'(rdata1), 32'(prev1));
      tick();

      // Reset inside the access window: no ack for the aborted read.
      set_req(0, 1'b0, 16'h0777, 16'h0);
      tick();
      if (AC >= 2) tick();
      rst = 1'b1;
      tick();
      rst  = 1'b0;
      v[0] = 1'b0;
      repeat (3) tick();
      chk(g, busy === 1'b0, "busy_after_reset", 32'(busy), 32'd0);
      set_req(0, 1'b0, 16'h2468, 16'h0);
      wait_ack(0);
      v[0] = 1'b0;
      tick();

      // Both ports back-to-back, then random gaps.
      fork
        run_port(0, 12, 0);
        run_port(1, 12, 0);
      join
      fork
        run_port(0, 40, 3);
        run_port(1, 40, 3);
      join
      repeat (AC + 4) tick();
      lane_done[g] = 1'b1;
    end
  end

  initial begin : finish_blk
    bit ok = 0;
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk);
      if (lane_done[0] && lane_done[1]) begin
        ok = 1;
        break;
      end
    end
    chk(-1, ok, "run_complete", 32'(ok), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
